// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline (E/M/W writer tracking).
// Define HAZARD_FWD_EN for full forwarding; otherwise every hazard stalls and all selects stay 0.
module hazard_fwd_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] tnew_D,
  input  logic [1:0] res_D,
  output logic       stall,
  output logic [3:0] mfcmp1_sel,
  output logic [3:0] mfcmp2_sel,
  output logic [3:0] mfalua_sel,
  output logic [3:0] mfalub_sel,
  output logic [3:0] mfdm_sel
);

  logic       vld_p0, vld_p1, vld_p2;
  logic [4:0] rs_p0, rt_p0, a3_p0;
  logic [1:0] tnew_p0, res_p0;
  logic [4:0] rt_p1, a3_p1;
  logic [1:0] tnew_p1, res_p1;
  logic [4:0] a3_p2;
  logic [1:0] res_p2;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // E stage: capture the D instruction, or a bubble while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset || stall) begin
      vld_p0  <= 1'b0;
      rs_p0   <= '0;
      rt_p0   <= '0;
      a3_p0   <= '0;
      tnew_p0 <= '0;
      res_p0  <= '0;
    end else begin
      vld_p0  <= (a3_D != 5'd0) && (res_D != 2'd0);
      rs_p0   <= rs_D;
      rt_p0   <= rt_D;
      a3_p0   <= a3_D;
      tnew_p0 <= tnew_D;
      res_p0  <= res_D;
    end
  end

  // M stage: one cycle closer to the result being available
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      rt_p1   <= '0;
      a3_p1   <= '0;
      tnew_p1 <= '0;
      res_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      rt_p1   <= rt_p0;
      a3_p1   <= a3_p0;
      tnew_p1 <= sat_dec(tnew_p0);
      res_p1  <= res_p0;
    end
  end

  // W stage: result is final, register file is written this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      a3_p2  <= '0;
      res_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      a3_p2  <= a3_p1;
      res_p2 <= res_p1;
    end
  end

  // A valid record always has a3 != 0, so a hit also implies the source is not $0.
  logic e_rs_hit, e_rt_hit, m_rs_hit, m_rt_hit;
  assign e_rs_hit = vld_p0 && (a3_p0 == rs_D);
  assign e_rt_hit = vld_p0 && (a3_p0 == rt_D);
  assign m_rs_hit = vld_p1 && (a3_p1 == rs_D);
  assign m_rt_hit = vld_p1 && (a3_p1 == rt_D);

`ifdef HAZARD_FWD_EN
  function automatic logic [3:0] fwd_code(input logic       m_hit,
                                          input logic [1:0] m_tnew,
                                          input logic [1:0] m_res,
                                          input logic       w_hit,
                                          input logic [1:0] w_res);
    logic [3:0] code;
    code = 4'd0;
    if (m_hit) begin
      if (m_tnew == 2'd0 && m_res == 2'd1)      code = 4'd1;
      else if (m_tnew == 2'd0 && m_res == 2'd3) code = 4'd2;
    end else if (w_hit) begin
      case (w_res)
        2'd1:    code = 4'd3;
        2'd2:    code = 4'd4;
        2'd3:    code = 4'd5;
        default: code = 4'd0;
      endcase
    end
    return code;
  endfunction

  assign stall = (e_rs_hit && (tuse_rs_D < tnew_p0)) || (m_rs_hit && (tuse_rs_D < tnew_p1)) ||
                 (e_rt_hit && (tuse_rt_D < tnew_p0)) || (m_rt_hit && (tuse_rt_D < tnew_p1));

  assign mfcmp1_sel = fwd_code(m_rs_hit, tnew_p1, res_p1,
                               vld_p2 && (a3_p2 == rs_D), res_p2);
  assign mfcmp2_sel = fwd_code(m_rt_hit, tnew_p1, res_p1,
                               vld_p2 && (a3_p2 == rt_D), res_p2);
  assign mfalua_sel = fwd_code(vld_p1 && (a3_p1 == rs_p0), tnew_p1, res_p1,
                               vld_p2 && (a3_p2 == rs_p0), res_p2);
  assign mfalub_sel = fwd_code(vld_p1 && (a3_p1 == rt_p0), tnew_p1, res_p1,
                               vld_p2 && (a3_p2 == rt_p0), res_p2);
  assign mfdm_sel   = fwd_code(1'b0, tnew_p1, res_p1,
                               vld_p2 && (a3_p2 == rt_p1), res_p2);
`else
  // Without forwarding any pending writer in E or M blocks the reader until it reaches W.
  assign stall = ((tuse_rs_D != 2'd3) && (e_rs_hit || m_rs_hit)) ||
                 ((tuse_rt_D != 2'd3) && (e_rt_hit || m_rt_hit));

  assign mfcmp1_sel = 4'd0;
  assign mfcmp2_sel = 4'd0;
  assign mfalua_sel = 4'd0;
  assign mfalub_sel = 4'd0;
  assign mfdm_sel   = 4'd0;

  logic unused_ok;
  assign unused_ok = ^{rs_p0, rt_p1, tnew_p1, vld_p2, a3_p2, res_p2};
`endif

endmodule
